// File: rtl/tx_pkg.sv
// Shared definitions for the 8-bit serial transmitter.
//   tx_state_t : FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   FRAME_BITS : bits per frame (start + 8 data + stop)
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/shift_reg_8b.sv
// 8-bit right-shifting register holding the byte being serialised.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   load  : capture d (wins over shift)
//   shift : shift right by one, zero fill
//   d     : parallel load value
//   q     : register contents; q[0] is the current data bit
module shift_reg_8b (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {1'b0, q[7:1]};
    end
  end

endmodule

// File: rtl/serial_tx_8b.sv
// Byte-to-serial transmitter: 1 start bit (0), 8 data bits LSB first,
// 1 stop bit (1), each CLKS_PER_BIT clock cycles long.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   in_val  : upstream byte valid
//   in_rdy  : block idle, byte accepted when in_val is also high
//   in_data : byte to send, captured on the accept edge
//   tx      : registered serial line, idles high
//   busy    : frame in progress
//   done    : one-cycle pulse in the first idle cycle after a frame
module serial_tx_8b
  import tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [7:0] in_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  tx_state_t  state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] idx, idx_nx;
  logic       tx_nx, done_nx;
  logic       bit_end, load, shift;
  logic [7:0] q;
  logic       unused_q_hi;

  shift_reg_8b u_sr (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (in_data),
    .q     (q)
  );

  // Upper shift-register bits only feed the shift chain.
  assign unused_q_hi = ^q[7:2];

  assign in_rdy  = (state == IDLE);
  assign busy    = (state != IDLE);
  assign load    = in_val && in_rdy;
  assign bit_end = (cnt == LAST_CNT);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        idx_nx = '0;
        if (in_val) state_nx = START;
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift  = 1'b1;
          cnt_nx = '0;
          if (idx == 3'd7) begin
            state_nx = STOP;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase

    // tx is registered from the next state so it lines up with state.
    // On a shift edge the bit that becomes q[0] is the current q[1].
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift ? q[1] : q[0];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      tx    <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      tx    <= tx_nx;
      done  <= done_nx;
    end
  end

endmodule
